// File: rtl/xblock_lsu_pkg.sv
// rtl/xblock_lsu_pkg.sv - shared encodings and defaults for the X-block load/store unit
package xblock_lsu_pkg;

    localparam int LSU_DATA_WIDTH = 16;
    localparam int LSU_ADDR_BITS  = 8;

    // Compute-unit phases, same values the register file decodes
    typedef enum logic [3:0] {
        CU_IDLE      = 4'd0,
        CU_FETCH     = 4'd1,
        CU_DECODE    = 4'd2,
        CU_REQ       = 4'd3,
        CU_WAIT      = 4'd4,
        CU_EXECUTE   = 4'd5,
        CU_WRITEBACK = 4'd6,
        CU_DONE      = 4'd7
    } cu_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } lsu_op_e;

    // A load wins when both decode flags are set
    function automatic lsu_op_e select_op(input logic rd, input logic wr);
        if (rd)      return OP_LOAD;
        else if (wr) return OP_STORE;
        else         return OP_NONE;
    endfunction

endpackage

// File: rtl/xblock_lsu.sv
// rtl/xblock_lsu.sv - per-X-block load/store unit with one valid/ready transaction per WAIT phase
module xblock_lsu
    import xblock_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_BITS  = LSU_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            cu_state,
    input  logic                  lsu_enable,
    input  logic                  is_read,
    input  logic                  is_write,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  mem_read_valid,
    output logic [ADDR_BITS-1:0]  mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_BITS-1:0]  mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
    output logic [1:0]            lsu_state,
    output logic [DATA_WIDTH-1:0] lsu_load_data
);

    lsu_state_e            state_q, state_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;

    lsu_op_e op;
    logic    accepted;

    // Upper operand bits only matter to other units; addresses are truncated here
    logic unused_upper_bits;
    assign unused_upper_bits = ^{rs1_data[DATA_WIDTH-1:ADDR_BITS], rs2_data[DATA_WIDTH-1:ADDR_BITS]};

    assign op       = select_op(is_read, is_write);
    assign accepted = (rd_valid_q && mem_read_ready) || (wr_valid_q && mem_write_ready);

    // Next-state and next-output logic; request outputs are set on entry so they are live in REQUESTING
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        load_d     = load_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_enable && (cu_state == CU_WAIT) && (op != OP_NONE)) begin
                    state_d = LSU_REQUESTING;
                    if (op == OP_LOAD) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rs2_data[ADDR_BITS-1:0];
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rs1_data[ADDR_BITS-1:0];
                        wr_data_d  = rs2_data;
                    end
                end
            end
            LSU_REQUESTING, LSU_WAITING: begin
                // Ready may already be high in the first valid cycle
                if (accepted) begin
                    state_d    = LSU_DONE;
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    if (rd_valid_q) begin
                        load_d = mem_read_data;
                    end
                end else begin
                    state_d = LSU_WAITING;
                end
            end
            LSU_DONE: begin
                if (cu_state == CU_WRITEBACK) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and output registers; reset drops any request in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            load_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            load_q     <= load_d;
        end
    end

    assign lsu_state         = state_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_load_data     = load_q;

endmodule

// File: tb/tb_xblock_lsu.sv
// tb/tb_xblock_lsu.sv - randomized self-checking bench for xblock_lsu against a transaction-level memory model
module tb_xblock_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cu_state;
    logic        lsu_enable;
    logic        is_read;
    logic        is_write;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        mem_write_valid;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic        mem_write_ready;
    logic [1:0]  lsu_state;
    logic [15:0] lsu_load_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [256];
    logic [15:0] exp_load;

    always #5 clk = ~clk;

    xblock_lsu dut (
        .clk               (clk),
        .reset             (reset),
        .cu_state          (cu_state),
        .lsu_enable        (lsu_enable),
        .is_read           (is_read),
        .is_write          (is_write),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .lsu_state         (lsu_state),
        .lsu_load_data     (lsu_load_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and land just after the edge, away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rv"}, {31'd0, mem_read_valid}, 32'd0);
        check_eq({tag, "_wv"}, {31'd0, mem_write_valid}, 32'd0);
    endtask

    // One compute-unit WAIT phase: the bench acts as memory, releasing ready after `stall` cycles
    task automatic run_txn(input bit rd, input bit wr, input bit en, input logic [15:0] a1,
                           input logic [15:0] a2, input int stall, input bit drop_en);
        bit          active;
        logic [7:0]  ea;
        logic [15:0] ed;
        active = en && (rd || wr);
        ea = rd ? (a2 & 16'h00FF) : (a1 & 16'h00FF);
        ed = a2;
        cu_state        = 4'd4;
        is_read         = rd;
        is_write        = wr;
        lsu_enable      = en;
        rs1_data        = a1;
        rs2_data        = a2;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (!active) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check_eq("inactive_state", {30'd0, lsu_state}, 32'd0);
                check_quiet("inactive");
            end
            check_eq("inactive_load", {16'd0, lsu_load_data}, {16'd0, exp_load});
            cu_state = 4'd0;
            return;
        end
        step();
        for (int i = 0; i <= stall; i++) begin
            check_eq("busy_state", {30'd0, lsu_state}, (i == 0) ? 32'd1 : 32'd2);
            check_eq("one_valid", {31'd0, mem_read_valid & mem_write_valid}, 32'd0);
            if (rd) begin
                check_eq("ld_rv", {31'd0, mem_read_valid}, 32'd1);
                check_eq("ld_wv", {31'd0, mem_write_valid}, 32'd0);
                check_eq("ld_addr", {24'd0, mem_read_address}, {24'd0, ea});
            end else begin
                check_eq("st_rv", {31'd0, mem_read_valid}, 32'd0);
                check_eq("st_wv", {31'd0, mem_write_valid}, 32'd1);
                check_eq("st_addr", {24'd0, mem_write_address}, {24'd0, ea});
                check_eq("st_data", {16'd0, mem_write_data}, {16'd0, ed});
            end
            check_eq("busy_load", {16'd0, lsu_load_data}, {16'd0, exp_load});
            if (drop_en) lsu_enable = 1'b0;
            if (rd) begin
                mem_read_ready = (i == stall);
                mem_read_data  = (i == stall) ? mem[ea] : 16'($urandom);
            end else begin
                mem_write_ready = (i == stall);
            end
            step();
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = 16'($urandom);
        if (rd) exp_load = mem[ea];
        else    mem[ea]  = ed;
        check_eq("done_state", {30'd0, lsu_state}, 32'd3);
        check_quiet("done");
        check_eq("done_load", {16'd0, lsu_load_data}, {16'd0, exp_load});
        cu_state = 4'd5;
        step();
        check_eq("hold_done", {30'd0, lsu_state}, 32'd3);
        check_quiet("hold");
        cu_state = 4'd6;
        step();
        check_eq("wb_idle", {30'd0, lsu_state}, 32'd0);
        check_eq("wb_load", {16'd0, lsu_load_data}, {16'd0, exp_load});
        check_quiet("wb");
        cu_state   = 4'd0;
        is_read    = 1'b0;
        is_write   = 1'b0;
        lsu_enable = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        exp_load        = 16'h0000;
        reset           = 1'b1;
        cu_state        = 4'd0;
        lsu_enable      = 1'b1;
        is_read         = 1'b0;
        is_write        = 1'b0;
        rs1_data        = 16'h0000;
        rs2_data        = 16'h0000;
        mem_read_ready  = 1'b0;
        mem_read_data   = 16'h0000;
        mem_write_ready = 1'b0;
        step();
        step();
        check_eq("rst_state", {30'd0, lsu_state}, 32'd0);
        check_quiet("rst");
        check_eq("rst_raddr", {24'd0, mem_read_address}, 32'd0);
        check_eq("rst_waddr", {24'd0, mem_write_address}, 32'd0);
        check_eq("rst_wdata", {16'd0, mem_write_data}, 32'd0);
        check_eq("rst_load", {16'd0, lsu_load_data}, 32'd0);
        reset = 1'b0;
        step();

        // Zero-wait load, then a stalled load, store with truncated address, both flags set
        mem[8'h12] = 16'hBEEF;
        run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0012, 0, 1'b0);
        check_eq("beef", {16'd0, lsu_load_data}, 32'h0000BEEF);
        run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0A77, 3, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 16'h0140, 16'h1234, 1, 1'b0);
        check_eq("store_mem", {16'd0, mem[8'h40]}, 32'h00001234);
        run_txn(1'b1, 1'b1, 1'b1, 16'h0055, 16'h0040, 2, 1'b0);
        check_eq("both_load", {16'd0, lsu_load_data}, 32'h00001234);

        // No start without enable or without an operation; enable dropped mid-flight still completes
        run_txn(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0002, 0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0099, 2, 1'b1);

        // Reset while WAITING drops the request at once
        cu_state   = 4'd4;
        is_read    = 1'b1;
        rs2_data   = 16'h0033;
        step();
        step();
        check_eq("pre_rst_rv", {31'd0, mem_read_valid}, 32'd1);
        check_eq("pre_rst_state", {30'd0, lsu_state}, 32'd2);
        reset = 1'b1;
        step();
        check_eq("mid_rst_state", {30'd0, lsu_state}, 32'd0);
        check_quiet("mid_rst");
        check_eq("mid_rst_raddr", {24'd0, mem_read_address}, 32'd0);
        check_eq("mid_rst_load", {16'd0, lsu_load_data}, 32'd0);
        exp_load = 16'h0000;
        reset    = 1'b0;
        cu_state = 4'd0;
        is_read  = 1'b0;
        step();
        run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0033, 1, 1'b0);

        // Randomized mix against the memory model
        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                    16'($urandom), 16'($urandom), $urandom_range(0, 4), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xblock_lsu.md
Name: xblock_lsu

Overview:
Per-X-block load/store unit; the producer of the load-writeback data and the consumer of the operand data that the X-block register file reads out. It takes register operands during the compute-unit WAIT phase, runs one valid/ready transaction on the data-memory read or write channel, and holds the loaded value stable for the register file to capture in WRITEBACK. One instance per X-block, driven by the same cu_state as the register file.

Parameters:
DATA_WIDTH, 16, width of register operands, memory data and load result
ADDR_BITS, 8, data-memory address width; taken from the low bits of the operand

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cu_state  input  4  compute-unit phase (IDLE=0, FETCH=1, DECODE=2, REQ=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7)
lsu_enable  input  1  this X-block is active; when low the LSU never leaves IDLE
is_read  input  1  decoded load instruction
is_write  input  1  decoded store instruction
rs1_data  input  DATA_WIDTH  register-file operand 1; store address
rs2_data  input  DATA_WIDTH  register-file operand 2; load address and store data
mem_read_valid  output  1  read request
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  memory accepts the read; mem_read_data is valid in the same cycle
mem_read_data  input  DATA_WIDTH  read return data
mem_write_valid  output  1  write request
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_WIDTH  write data
mem_write_ready  input  1  memory accepts the write
lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3
lsu_load_data  output  DATA_WIDTH  registered load result, read by the register file in WRITEBACK

Behaviour:
- All outputs are registered. On reset, in any state, all outputs are 0 and lsu_state is IDLE. Reset mid-transaction drops the request immediately and does not wait for ready.
- Operation selection: op = is_read ? load : (is_write ? store : none). If both are set, only a load is performed.
- IDLE -> REQUESTING when lsu_enable and cu_state==WAIT and op is not none. Otherwise stay in IDLE.
- REQUESTING, one cycle:
  - Load: drive mem_read_valid=1 and mem_read_address=rs2_data[ADDR_BITS-1:0].
  - Store: drive mem_write_valid=1, mem_write_address=rs1_data[ADDR_BITS-1:0], mem_write_data=rs2_data.
  - Operands are sampled here; they are stable because the register file's outputs are registered and change only in REQ.
  - Next state is WAITING.
- WAITING: hold the valid signal, address and data constant until the matching ready is sampled high.
  - Load: on mem_read_ready, lsu_load_data <= mem_read_data.
  - On ready, deassert valid in the next cycle and go to DONE.
  - No timeout: wait indefinitely.
- DONE: stay until cu_state==WRITEBACK, then go to IDLE in the next cycle.
- Latency: WAIT seen at cycle N; valid high from N+1; ready first seen at cycle M (M >= N+1); DONE at M+1. The minimum is DONE at N+2.
- The compute-unit scheduler must hold cu_state in WAIT while lsu_state is REQUESTING or WAITING. A change of cu_state during those states does not abort the transaction.
- At most one outstanding transaction; read and write valid are never high in the same cycle.
- lsu_load_data keeps its value until the next completed load. Stores do not change it.
- lsu_enable going low mid-transaction does not abort; it only blocks new starts from IDLE.
- Address operands wider than ADDR_BITS are truncated; the upper bits are ignored.

Decomposition:
- The shared package holds:
  - the cu_state encodings (the same values the register file uses);
  - the lsu_state encodings;
  - default DATA_WIDTH and ADDR_BITS.
- No sub-module: a single FSM plus output registers, about 150 lines.

Test Plan:
- Load, zero-wait: rs2_data=0x0012, is_read=1, cu_state=WAIT; mem_read_ready=1 with mem_read_data=0xBEEF in the first valid cycle -> mem_read_address=0x12 for exactly 1 cycle, lsu_state DONE two cycles after WAIT, lsu_load_data=0xBEEF; cu_state=WRITEBACK -> IDLE next cycle.
- Load, 3-cycle stall: mem_read_ready held low for 3 cycles -> valid and address held constant 4 cycles, data captured only on the ready cycle, no second request.
- Store: rs1_data=0x0140, rs2_data=0x1234, is_write=1 -> mem_write_address=0x40 (truncated), mem_write_data=0x1234; lsu_load_data unchanged from the previous load; mem_read_valid never asserted.
- is_read=is_write=1 -> only mem_read_valid asserts; mem_write_valid stays 0 throughout.
- lsu_enable=0 or op none with cu_state=WAIT -> lsu_state stays IDLE and no valid asserts. Separately, lsu_enable dropped while WAITING -> the transaction completes to DONE.
- Reset asserted in WAITING with mem_read_valid=1 -> the next cycle has all outputs 0 and lsu_state IDLE; a later clean load works normally.
